// File: rtl/pmem_arbiter.sv
// Shared physical-memory arbiter between the I-cache and the D-cache.
// A granted request is latched into registered mem_* strobes and held until
// mem_resp; the response is routed combinationally to the granted client only.
// Simultaneous requests alternate using the last-served client (rr_last).
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        I_SERVE,
        D_SERVE
    } state_t;

    typedef enum logic {
        CL_I,
        CL_D
    } client_t;

    state_t                  state_q,       state_d;
    client_t                 rr_last_q,     rr_last_d;
    logic                    mem_read_q,    mem_read_d;
    logic                    mem_write_q,   mem_write_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [LINE_WIDTH-1:0]   mem_wdata_q,   mem_wdata_d;

    logic                    i_req;
    logic                    d_req;
    logic                    grant_i;
    logic                    grant_d;

    // State and latched memory command registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_last_q     <= CL_I;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    // Grant selection in IDLE, completion and response routing while serving
    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        i_pmem_resp   = 1'b0;
        d_pmem_resp   = 1'b0;
        grant_i       = 1'b0;
        grant_d       = 1'b0;
        i_req         = i_pmem_read;
        d_req         = d_pmem_read | d_pmem_write;

        unique case (state_q)
            IDLE: begin
                // D wins when alone, or on a tie when I was served last
                grant_d = d_req && (!i_req || rr_last_q == CL_I);
                grant_i = i_req && !grant_d;
                if (grant_d) begin
                    state_d       = D_SERVE;
                    mem_write_d   = d_pmem_write;
                    mem_read_d    = !d_pmem_write;
                    mem_address_d = d_pmem_address;
                    mem_wdata_d   = d_pmem_wdata;
                end else if (grant_i) begin
                    state_d       = I_SERVE;
                    mem_read_d    = 1'b1;
                    mem_write_d   = 1'b0;
                    mem_address_d = i_pmem_address;
                end
            end
            I_SERVE: begin
                if (mem_resp) begin
                    i_pmem_resp = !rst;
                    rr_last_d   = CL_I;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            D_SERVE: begin
                if (mem_resp) begin
                    d_pmem_resp = !rst;
                    rr_last_d   = CL_D;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_address  = mem_address_q;
    assign mem_wdata    = mem_wdata_q;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios followed by randomized client and
// memory traffic, all checked cycle by cycle against a transaction-level model.
module tb_pmem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: one outstanding transaction and who was served last
    bit            m_busy;
    bit            m_own_d;
    bit            m_last_d;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;

    // Memory responder and client bookkeeping
    bit          mem_auto;
    bit          mem_stray;
    int unsigned mem_lat_min;
    int unsigned mem_lat_max;
    bit          mem_started;
    int unsigned mem_cnt;
    bit          i_keep, d_keep, i_done, d_done;
    int unsigned i_resp_cnt, d_resp_cnt;
    string       order[$];

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive memory side, check outputs, advance the model
    task automatic tick();
        bit ir, dr, take_d;
        if (i_done && !i_keep) i_pmem_read = 1'b0;
        if (d_done && !d_keep) begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
        end
        i_done = 1'b0;
        d_done = 1'b0;

        if (mem_auto) begin
            mem_resp = 1'b0;
            if (mem_read || mem_write) begin
                if (!mem_started) begin
                    mem_started = 1'b1;
                    mem_cnt     = $urandom_range(mem_lat_max, mem_lat_min);
                end
                if (mem_cnt == 0) begin
                    mem_resp    = 1'b1;
                    mem_started = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end else begin
                mem_started = 1'b0;
                if (mem_stray && $urandom_range(19, 0) == 0) mem_resp = 1'b1;
            end
            for (int k = 0; k < LW / 32; k++) mem_rdata[k*32 +: 32] = $urandom;
        end

        #1;
        chk("mem_read",    LW'(mem_read),    LW'(m_busy && !m_wr));
        chk("mem_write",   LW'(mem_write),   LW'(m_busy && m_wr));
        chk("mem_address", LW'(mem_address), LW'(m_addr));
        if (m_busy && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
        chk("i_pmem_resp", LW'(i_pmem_resp), LW'(m_busy && !m_own_d && mem_resp && !rst));
        chk("d_pmem_resp", LW'(d_pmem_resp), LW'(m_busy && m_own_d && mem_resp && !rst));
        chk("i_pmem_rdata", i_pmem_rdata, mem_rdata);
        chk("d_pmem_rdata", d_pmem_rdata, mem_rdata);

        if (i_pmem_resp) begin i_done = 1'b1; i_resp_cnt++; order.push_back("I"); end
        if (d_pmem_resp) begin d_done = 1'b1; d_resp_cnt++; order.push_back("D"); end

        if (rst) begin
            m_busy   = 1'b0;
            m_last_d = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
        end else if (m_busy) begin
            if (mem_resp) begin
                m_busy   = 1'b0;
                m_last_d = m_own_d;
            end
        end else begin
            ir = i_pmem_read;
            dr = d_pmem_read || d_pmem_write;
            if (ir || dr) begin
                take_d  = dr && (!ir || !m_last_d);
                m_busy  = 1'b1;
                m_own_d = take_d;
                if (take_d) begin
                    m_wr    = d_pmem_write;
                    m_addr  = d_pmem_address;
                    m_wdata = d_pmem_wdata;
                end else begin
                    m_wr   = 1'b0;
                    m_addr = i_pmem_address;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Random client behaviour: new requests, rare address churn and abandonment
    task automatic gen_clients();
        if (i_done) begin i_pmem_read = 1'b0; i_done = 1'b0; end
        if (!i_pmem_read) begin
            if ($urandom_range(1, 0) == 1) begin
                i_pmem_read    = 1'b1;
                i_pmem_address = $urandom & ~32'h1f;
            end
        end else if ($urandom_range(15, 0) == 0) begin
            i_pmem_address = $urandom;
        end else if ($urandom_range(31, 0) == 0) begin
            i_pmem_read = 1'b0;
        end

        if (d_done) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_done = 1'b0; end
        if (!(d_pmem_read || d_pmem_write)) begin
            if ($urandom_range(1, 0) == 1) begin
                case ($urandom_range(2, 0))
                    0:       begin d_pmem_read = 1'b1; d_pmem_write = 1'b0; end
                    1:       begin d_pmem_read = 1'b0; d_pmem_write = 1'b1; end
                    default: begin d_pmem_read = 1'b1; d_pmem_write = 1'b1; end
                endcase
                d_pmem_address = $urandom & ~32'h1f;
                for (int k = 0; k < LW / 32; k++) d_pmem_wdata[k*32 +: 32] = $urandom;
            end
        end else if ($urandom_range(15, 0) == 0) begin
            d_pmem_address = $urandom;
            d_pmem_wdata   = ~d_pmem_wdata;
        end else if ($urandom_range(31, 0) == 0) begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
        end
    endtask

    initial begin
        int unsigned cnt;
        rst = 1'b1;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        mem_auto = 1'b1; mem_stray = 1'b0; mem_lat_min = 3; mem_lat_max = 3;
        mem_started = 1'b0; mem_cnt = 0;
        i_keep = 1'b0; d_keep = 1'b0; i_done = 1'b0; d_done = 1'b0;
        i_resp_cnt = 0; d_resp_cnt = 0;
        m_busy = 1'b0; m_own_d = 1'b0; m_last_d = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
        @(negedge clk);
        tick();
        do_reset();
        chk("reset_addr", LW'(mem_address), '0);

        // I-only fill, with the client changing its address while being served
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1240;
        i_resp_cnt = 0; d_resp_cnt = 0; cnt = 0;
        while (!i_done && cnt < 30) begin
            if (cnt == 2) i_pmem_address = 32'hDEAD_0000;
            tick();
            cnt++;
        end
        chk("i_only_done", LW'(i_done), LW'(1'b1));
        chk("i_only_addr", LW'(mem_address), LW'(32'h0000_1240));
        chk("i_only_resp_cnt", LW'(i_resp_cnt), LW'(1));
        chk("i_only_d_resp_cnt", LW'(d_resp_cnt), LW'(0));
        tick(); tick();

        // Tie right after reset: D write first, then I read
        do_reset();
        order.delete(); mem_lat_min = 2; mem_lat_max = 2;
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0100;
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0200;
        for (int k = 0; k < LW / 32; k++) d_pmem_wdata[k*32 +: 32] = 32'hA5A5_0000 + k;
        cnt = 0;
        while (order.size() < 2 && cnt < 50) begin tick(); cnt++; end
        chk("tie_count", LW'(order.size()), LW'(2));
        if (order.size() >= 2) begin
            chk("tie_first_is_d", LW'(order[0] == "D"), LW'(1'b1));
            chk("tie_second_is_i", LW'(order[1] == "I"), LW'(1'b1));
        end
        tick(); tick();

        // Fairness: both clients request continuously
        do_reset();
        order.delete(); mem_lat_min = 1; mem_lat_max = 3;
        i_keep = 1'b1; d_keep = 1'b1;
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0300;
        d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0400;
        cnt = 0;
        while (order.size() < 6 && cnt < 200) begin tick(); cnt++; end
        chk("fair_count", LW'(order.size()), LW'(6));
        for (int k = 0; k < 6 && k < order.size(); k++)
            chk($sformatf("fair_grant_%0d", k), LW'(order[k] == ((k % 2 == 0) ? "D" : "I")), LW'(1'b1));
        i_keep = 1'b0; d_keep = 1'b0;
        i_pmem_read = 1'b0; d_pmem_read = 1'b0; i_done = 1'b0; d_done = 1'b0;
        tick(); tick();

        // Reset in the middle of a D writeback, then a stray mem_resp in IDLE
        do_reset();
        mem_lat_min = 10; mem_lat_max = 10;
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0200;
        tick(); tick(); tick();
        chk("rst_mid_serving", LW'(mem_write), LW'(1'b1));
        i_resp_cnt = 0; d_resp_cnt = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0; d_pmem_write = 1'b0;
        tick();
        chk("rst_mid_mem_write", LW'(mem_write), LW'(1'b0));
        mem_auto = 1'b0; mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        tick();
        mem_auto = 1'b1;
        chk("rst_stray_resp_cnt", LW'(i_resp_cnt + d_resp_cnt), LW'(0));

        // Randomized traffic with variable memory latency, stray responses, rare resets
        mem_lat_min = 0; mem_lat_max = 4; mem_stray = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(499, 0) == 0);
            gen_clients();
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
